uart_tx_param: RTL and testbench

//   Parametrised UART transmitter running on the system clock with an internal baud divider.

---
 rtl/uart_tx_param_if.sv | 27 ++
 rtl/uart_tx_param.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_param.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/uart_tx_param_if.sv
// Handshake bundle between the CPU-side register and the UART transmitter.
// The master drives the request and the payload. The slave returns the line, busy and done.
interface uart_tx_param_if #(
    parameter int unsigned DATA_BITS = 8
) ();
    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data_in;
    logic                 serial_tx;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output tx_start,
        output tx_data_in,
        input  serial_tx,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data_in,
        output serial_tx,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, DATA_BITS LSB-first, optional parity, STOP_BITS.
// The parity bit is built only when the UART_TX_PARITY_EN macro is defined.
module uart_tx_param #(
    parameter int unsigned CLKS_PER_BIT = 10416,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic             clock,
    input  logic             reset,
    uart_tx_param_if.slave   bus
);

    localparam int unsigned DIV_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || PARITY_ODD > 1) begin : g_bad_param
        $error("uart_tx_param: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    state_e               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state logic; the line level for the next bit is decided on the edge that enters it.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        bit_end = (div_q == DIV_W'(CLKS_PER_BIT - 1));

        if (state_q != S_IDLE) begin
            div_d = bit_end ? '0 : div_q + DIV_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                div_d = '0;
                if (bus.tx_start) begin
                    state_d = S_START;
                    shift_d = bus.tx_data_in;
                    idx_d   = '0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_d   = 1'(PARITY_ODD);
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
`ifdef UART_TX_PARITY_EN
                    par_d   = par_q ^ shift_q[0];
`endif
                    if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                        idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = par_q ^ shift_q[0];
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        tx_d  = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    idx_d   = '0;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (idx_q == IDX_W'(STOP_BITS - 1)) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                div_d   = '0;
                idx_d   = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.serial_tx = tx_q;
    assign bus.tx_busy   = busy_q;
    assign bus.tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: an 8-bit/1-stop instance and a 7-bit/2-stop odd-parity instance.
// Expected line levels come from a frame list built arithmetically from the data byte.
module tb_uart_tx_param;

    localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned PEN = 1;
`else
    localparam int unsigned PEN = 0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tx_start = 1'b0;
    logic [8:0] tx_data = '0;
    logic       sel = 1'b0;
    logic       mon_tx, mon_busy, mon_done;
    int         checks = 0;
    int         failures = 0;

    always #5 clock = ~clock;

    uart_tx_param_if #(.DATA_BITS(8)) b0 ();
    uart_tx_param_if #(.DATA_BITS(7)) b1 ();

    assign b0.tx_start   = tx_start & ~sel;
    assign b0.tx_data_in = tx_data[7:0];
    assign b1.tx_start   = tx_start & sel;
    assign b1.tx_data_in = tx_data[6:0];

    assign mon_tx   = sel ? b1.serial_tx : b0.serial_tx;
    assign mon_busy = sel ? b1.tx_busy   : b0.tx_busy;
    assign mon_done = sel ? b1.tx_done   : b0.tx_done;

    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (b0)
    );

    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (b1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller has just presented the request at a negedge; the accept happens on the next posedge.
    task automatic check_frame(input logic s, input logic [8:0] d, input bit hold,
                               input int poke_k, input logic [8:0] nd);
        int   dbits, sbits, odd, ones, total, busy_cnt, done_cnt;
        bit   frame[$];
        dbits    = s ? 7 : 8;
        sbits    = s ? 2 : 1;
        odd      = s ? 1 : 0;
        ones     = 0;
        busy_cnt = 0;
        done_cnt = 0;
        frame.push_back(1'b0);
        for (int i = 0; i < dbits; i++) begin
            frame.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (PEN == 1) frame.push_back(bit'((ones % 2) ^ odd));
        for (int i = 0; i < sbits; i++) frame.push_back(1'b1);
        total = frame.size() * CPB;
        for (int k = 0; k <= total; k++) begin
            @(negedge clock);
            if (k == 1) begin
                if (hold) tx_data = nd;
                else      tx_start = 1'b0;
            end
            if (poke_k >= 0 && k == poke_k) begin
                tx_start = 1'b1;
                tx_data  = 9'h1FF;
            end
            if (poke_k >= 0 && k == poke_k + 1) tx_start = 1'b0;
            if (k < total) chk("line_level", 32'(mon_tx), 32'(frame[k / CPB]));
            else           chk("line_after_stop", 32'(mon_tx), 32'd1);
            busy_cnt += int'(mon_busy);
            done_cnt += int'(mon_done);
            if (k == total) chk("busy_done_at_end", 32'({mon_busy, mon_done}), 32'b01);
        end
        chk("busy_length", 32'(busy_cnt), 32'(total));
        chk("done_pulses", 32'(done_cnt), 32'd1);
        if (!hold) begin
            @(negedge clock);
            chk("idle_after_frame", 32'({mon_tx, mon_busy, mon_done}), 32'b100);
        end
    endtask

    task automatic send(input logic s, input logic [8:0] d, input bit hold,
                        input int poke_k, input logic [8:0] nd);
        @(negedge clock);
        sel      = s;
        tx_start = 1'b1;
        tx_data  = d;
        check_frame(s, d, hold, poke_k, nd);
    endtask

    initial begin
        // Reset held three cycles, then the idle line must stay quiet.
        repeat (3) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk("reset_idle_dut0", 32'({b0.serial_tx, b0.tx_busy, b0.tx_done}), 32'b100);
            chk("reset_idle_dut1", 32'({b1.serial_tx, b1.tx_busy, b1.tx_done}), 32'b100);
        end

        // Alternating pattern.
        send(1'b0, 9'h055, 1'b0, -1, 9'h000);

        // A request during data bit 3 is ignored and no second frame follows.
        send(1'b0, 9'h0A5, 1'b0, 17, 9'h000);

        // Held request: two frames separated by one extra idle clock.
        send(1'b0, 9'h0A5, 1'b1, -1, 9'h03C);
        check_frame(1'b0, 9'h03C, 1'b0, -1, 9'h000);

        // Second configuration and the parity pattern.
        send(1'b0, 9'h007, 1'b0, -1, 9'h000);
        send(1'b1, 9'h07F, 1'b0, -1, 9'h000);
        send(1'b1, 9'h007, 1'b0, -1, 9'h000);

        // Random payloads on both instances.
        for (int i = 0; i < 8; i++) begin
            send(1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)), 1'b0, -1, 9'h000);
        end

        // Reset during data bit 4 aborts the frame without a done pulse.
        @(negedge clock);
        sel      = 1'b0;
        tx_start = 1'b1;
        tx_data  = 9'h0A5;
        @(negedge clock);
        tx_start = 1'b0;
        repeat (21) @(negedge clock);
        chk("pre_abort_bit4", 32'({mon_tx, mon_busy}), 32'b01);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_state", 32'({mon_tx, mon_busy, mon_done}), 32'b100);
        reset = 1'b0;
        @(negedge clock);
        chk("abort_no_done", 32'({mon_tx, mon_busy, mon_done}), 32'b100);
        send(1'b0, 9'h081, 1'b0, -1, 9'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
